// File: rtl/mem_access_unit_if.sv
// Word-bus handshake between the memory access unit and data memory.
// master: drives req/we/addr/be/wdata; slave: returns gnt/rvalid/rdata.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle RV32I data-memory access unit: one handshaked word-bus
// transaction per load/store, with lane steering, load extension,
// misalign detection and a bus timeout. Core side: mem_en_i, MemRW_i,
// DataWSel_i, DataRSel_i, addr_i, wdata_i in; stall_o, done_o,
// rdata_o, misalign_o, bus_err_o out. Bus side: bus (master modport).
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic        MemRW_i,
    input  logic [1:0]  DataWSel_i,
    input  logic [2:0]  DataRSel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    mem_access_unit_if.master bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      rsel_q, rsel_d;
    logic [1:0]      lo_q, lo_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wd_q, wd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;

    size_e           size;
    logic [3:0]      be_n;
    logic [31:0]     wd_n;
    logic            mis_n;
    logic            tmo;
    logic [31:0]     sh;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [31:0]     ld_fmt;

    // Access size comes from whichever select applies to the direction.
    always_comb begin
        size = SZ_W;
        if (MemRW_i) begin
            unique case (DataWSel_i)
                2'b01:   size = SZ_B;
                2'b11:   size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            unique case (DataRSel_i)
                3'b001, 3'b011: size = SZ_B;
                3'b010, 3'b100: size = SZ_H;
                default:        size = SZ_W;
            endcase
        end
    end

    always_comb begin
        be_n  = 4'b1111;
        wd_n  = wdata_i;
        mis_n = 1'b0;
        unique case (size)
            SZ_B: begin
                be_n = 4'b0001 << addr_i[1:0];
                wd_n = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_n  = addr_i[1] ? 4'b1100 : 4'b0011;
                wd_n  = {2{wdata_i[15:0]}};
                mis_n = addr_i[0];
            end
            default: mis_n = (addr_i[1:0] != 2'b00);
        endcase
    end

    // Load lane steering and extension from the registered offset/mode.
    always_comb begin
        sh = bus.bus_rdata >> {lo_q, 3'b000};
        lb = sh[7:0];
        lh = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        unique case (rsel_q)
            3'b001:  ld_fmt = {{24{lb[7]}}, lb};
            3'b010:  ld_fmt = {{16{lh[15]}}, lh};
            3'b011:  ld_fmt = {24'b0, lb};
            3'b100:  ld_fmt = {16'b0, lh};
            default: ld_fmt = bus.bus_rdata;
        endcase
    end

    // Limit is checked on the TIMEOUT-th REQ/RESP cycle; >= keeps it
    // firing if a late grant pushed the count past the limit.
    assign tmo = (TIMEOUT != 0) && (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        rsel_d  = rsel_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_en_i) begin
                    we_d    = MemRW_i;
                    rsel_d  = DataRSel_i;
                    lo_d    = addr_i[1:0];
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = be_n;
                    wd_d    = wd_n;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (mis_n) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.bus_gnt) begin
                    state_d = S_RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.bus_rvalid) begin
                    rdata_d = we_q ? 32'b0 : ld_fmt;
                    state_d = S_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                mis_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            rsel_q  <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rsel_q  <= rsel_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign stall_o = ~rst & (((state_q == S_IDLE) & mem_en_i)
                   | (state_q == S_REQ) | (state_q == S_RESP));
    assign done_o     = (state_q == S_DONE);
    assign rdata_o    = rdata_q;
    assign misalign_o = mis_q;
    assign bus_err_o  = err_q;

    assign bus.bus_req   = (state_q == S_REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: main instance (default timeout)
// plus a TIMEOUT=4 instance for abort and misalign-priority scenarios.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_en2 = 1'b0;
    logic        MemRW = 1'b0;
    logic [1:0]  DataWSel = 2'b00;
    logic [2:0]  DataRSel = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata;
    logic        stall2, done2, misalign2, bus_err2;
    logic [31:0] rdata2;

    int checks = 0;
    int errors = 0;

    // Results of the last do_access call.
    int          r_lat, r_stalls, r_reqs;
    logic [31:0] r_rdata, r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_we, r_mis, r_err, r_unstable, r_stall_done;

    mem_access_unit_if bus();
    mem_access_unit_if bus2();

    mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_en_i(mem_en), .MemRW_i(MemRW),
        .DataWSel_i(DataWSel), .DataRSel_i(DataRSel), .addr_i(addr),
        .wdata_i(wdata), .stall_o(stall), .done_o(done),
        .rdata_o(rdata), .misalign_o(misalign), .bus_err_o(bus_err),
        .bus(bus)
    );

    mem_access_unit #(.TIMEOUT(4)) dut2 (
        .clk(clk), .rst(rst), .mem_en_i(mem_en2), .MemRW_i(MemRW),
        .DataWSel_i(DataWSel), .DataRSel_i(DataRSel), .addr_i(addr),
        .wdata_i(wdata), .stall_o(stall2), .done_o(done2),
        .rdata_o(rdata2), .misalign_o(misalign2), .bus_err_o(bus_err2),
        .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata = 32'h0;
        bus2.bus_gnt = 1'b0;
        bus2.bus_rvalid = 1'b0;
        bus2.bus_rdata = 32'h0;
    end

    // Launches one access on the main instance and plays a slave that
    // grants after gwait request cycles and responds the cycle after.
    task automatic do_access(input logic we, input logic [1:0] ws,
                             input logic [2:0] rs, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int gwait);
        int   w = 0;
        logic pend = 1'b0;
        r_lat = -1; r_stalls = 0; r_reqs = 0; r_unstable = 1'b0;
        r_rdata = 32'hx; r_mis = 1'bx; r_err = 1'bx; r_stall_done = 1'bx;
        r_addr = 32'h0; r_be = 4'h0; r_wd = 32'h0; r_we = 1'b0;
        @(negedge clk);
        mem_en = 1'b1; MemRW = we; DataWSel = ws; DataRSel = rs;
        addr = a; wdata = wd; bus.bus_rdata = rd;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                r_lat = c; r_rdata = rdata; r_mis = misalign;
                r_err = bus_err; r_stall_done = stall;
                break;
            end
            bus.bus_rvalid = pend;
            pend = 1'b0;
            if (bus.bus_req) begin
                if (r_reqs == 0) begin
                    r_addr = bus.bus_addr; r_be = bus.bus_be;
                    r_wd = bus.bus_wdata; r_we = bus.bus_we;
                end else if (r_addr !== bus.bus_addr || r_be !== bus.bus_be ||
                             r_wd !== bus.bus_wdata || r_we !== bus.bus_we) begin
                    r_unstable = 1'b1;
                end
                r_reqs++;
                if (w >= gwait) begin
                    bus.bus_gnt = 1'b1; pend = 1'b1;
                end else begin
                    bus.bus_gnt = 1'b0; w++;
                end
            end else begin
                bus.bus_gnt = 1'b0;
            end
            #1;
            if (stall) r_stalls++;
        end
        mem_en = 1'b0;
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_en = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL rst_stall got %b exp 0", stall);
        end
        checks++;
        if ({done, misalign, bus_err, rdata} !== 35'h0) begin
            errors++;
            $display("FAIL rst_core got %b%b%b %h exp 000 0", done, misalign, bus_err, rdata);
        end
        checks++;
        if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !== 70'h0) begin
            errors++;
            $display("FAIL rst_bus got req %b we %b a %h be %b wd %h exp all 0",
                     bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata);
        end
        mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_byte();
        do_access(1'b1, 2'b01, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 0);
        checks++;
        if (r_lat !== 3) begin
            errors++; $display("FAIL sb_lat got %0d exp 3", r_lat);
        end
        checks++;
        if (r_addr !== 32'h1000 || r_be !== 4'b1000 || r_we !== 1'b1) begin
            errors++; $display("FAIL sb_bus got a %h be %b we %b exp 1000 1000 1", r_addr, r_be, r_we);
        end
        checks++;
        if (r_wd !== 32'hABAB_ABAB) begin
            errors++; $display("FAIL sb_wdata got %h exp ababadab-rep ABABABAB", r_wd);
        end
        checks++;
        if (r_stalls !== 3 || r_stall_done !== 1'b0 || r_reqs !== 1) begin
            errors++;
            $display("FAIL sb_stall got st %0d sd %b rq %0d exp 3 0 1", r_stalls, r_stall_done, r_reqs);
        end
        checks++;
        if (r_rdata !== 32'h0 || r_mis !== 1'b0 || r_err !== 1'b0) begin
            errors++; $display("FAIL sb_flags got %h %b %b exp 0 0 0", r_rdata, r_mis, r_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL sb_pulse got done %b exp 0", done);
        end
    endtask

    task automatic test_store_half();
        do_access(1'b1, 2'b11, 3'b000, 32'h1002, 32'h1234_ABCD, 32'h0, 0);
        checks++;
        if (r_be !== 4'b1100 || r_wd !== 32'hABCD_ABCD || r_lat !== 3) begin
            errors++; $display("FAIL sh_bus got be %b wd %h lat %0d exp 1100 ABCDABCD 3", r_be, r_wd, r_lat);
        end
    endtask

    task automatic test_load_byte();
        do_access(1'b0, 2'b00, 3'b001, 32'h2002, 32'h0, 32'h00F3_0000, 0);
        checks++;
        if (r_rdata !== 32'hFFFF_FFF3 || r_be !== 4'b0100 || r_we !== 1'b0) begin
            errors++; $display("FAIL lb_s got %h be %b we %b exp FFFFFFF3 0100 0", r_rdata, r_be, r_we);
        end
        do_access(1'b0, 2'b00, 3'b011, 32'h2002, 32'h0, 32'h00F3_0000, 0);
        checks++;
        if (r_rdata !== 32'h0000_00F3 || r_lat !== 3) begin
            errors++; $display("FAIL lb_u got %h lat %0d exp 000000F3 3", r_rdata, r_lat);
        end
    endtask

    task automatic test_load_half_wait();
        do_access(1'b0, 2'b00, 3'b010, 32'h2002, 32'h0, 32'h8001_0000, 3);
        checks++;
        if (r_rdata !== 32'hFFFF_8001 || r_be !== 4'b1100) begin
            errors++; $display("FAIL lh_s got %h be %b exp FFFF8001 1100", r_rdata, r_be);
        end
        checks++;
        if (r_lat !== 6 || r_stalls !== 6 || r_reqs !== 4) begin
            errors++;
            $display("FAIL lh_wait got lat %0d st %0d rq %0d exp 6 6 4", r_lat, r_stalls, r_reqs);
        end
        checks++;
        if (r_unstable !== 1'b0 || r_addr !== 32'h2000) begin
            errors++; $display("FAIL lh_stable got unst %b a %h exp 0 2000", r_unstable, r_addr);
        end
        do_access(1'b0, 2'b00, 3'b100, 32'h2000, 32'h0, 32'h1234_8001, 0);
        checks++;
        if (r_rdata !== 32'h0000_8001 || r_be !== 4'b0011) begin
            errors++; $display("FAIL lh_u got %h be %b exp 00008001 0011", r_rdata, r_be);
        end
    endtask

    task automatic test_load_word();
        do_access(1'b0, 2'b00, 3'b000, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0);
        checks++;
        if (r_rdata !== 32'hDEAD_BEEF || r_be !== 4'b1111) begin
            errors++; $display("FAIL lw got %h be %b exp DEADBEEF 1111", r_rdata, r_be);
        end
        do_access(1'b0, 2'b00, 3'b111, 32'h4004, 32'h0, 32'h8765_4321, 1);
        checks++;
        if (r_rdata !== 32'h8765_4321 || r_lat !== 4) begin
            errors++; $display("FAIL lw_rsel7 got %h lat %0d exp 87654321 4", r_rdata, r_lat);
        end
    endtask

    task automatic test_misalign();
        do_access(1'b0, 2'b00, 3'b000, 32'h3001, 32'h0, 32'hFFFF_FFFF, 0);
        checks++;
        if (r_lat !== 1 || r_mis !== 1'b1 || r_err !== 1'b0) begin
            errors++; $display("FAIL mis_lw got lat %0d mis %b err %b exp 1 1 0", r_lat, r_mis, r_err);
        end
        checks++;
        if (r_reqs !== 0 || r_rdata !== 32'h0 || r_stalls !== 1) begin
            errors++;
            $display("FAIL mis_lw_bus got rq %0d rd %h st %0d exp 0 0 1", r_reqs, r_rdata, r_stalls);
        end
        do_access(1'b1, 2'b11, 3'b000, 32'h1001, 32'h5555, 32'h0, 0);
        checks++;
        if (r_mis !== 1'b1 || r_reqs !== 0 || r_lat !== 1) begin
            errors++; $display("FAIL mis_sh got mis %b rq %0d lat %0d exp 1 0 1", r_mis, r_reqs, r_lat);
        end
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mis_pulse got mis %b done %b exp 0 0", misalign, done);
        end
    endtask

    task automatic test_timeout();
        int lat = -1;
        int reqs = 0;
        logic err = 1'b0;
        logic req_at = 1'b1;
        logic [31:0] rd = 32'hx;
        @(negedge clk);
        mem_en2 = 1'b1; MemRW = 1'b0; DataRSel = 3'b000; addr = 32'h5000;
        bus2.bus_gnt = 1'b1; bus2.bus_rvalid = 1'b0; bus2.bus_rdata = 32'h1111_2222;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (done2) begin
                lat = c; err = bus_err2; rd = rdata2; req_at = bus2.bus_req;
                break;
            end
            if (bus2.bus_req) reqs++;
        end
        mem_en2 = 1'b0;
        checks++;
        if (lat !== 5 || err !== 1'b1) begin
            errors++; $display("FAIL to_done got lat %0d err %b exp 5 1", lat, err);
        end
        checks++;
        if (rd !== 32'h0 || req_at !== 1'b0 || reqs !== 1 || misalign2 !== 1'b0) begin
            errors++;
            $display("FAIL to_out got rd %h req %b rq %0d mis %b exp 0 0 1 0", rd, req_at, reqs, misalign2);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || bus_err2 !== 1'b0) begin
            errors++; $display("FAIL to_pulse got done %b err %b exp 0 0", done2, bus_err2);
        end
        bus2.bus_gnt = 1'b0;
        mem_en2 = 1'b1; MemRW = 1'b1; DataWSel = 2'b00; addr = 32'h5002;
        @(negedge clk);
        mem_en2 = 1'b0;
        checks++;
        if (done2 !== 1'b1 || misalign2 !== 1'b1 || bus_err2 !== 1'b0) begin
            errors++;
            $display("FAIL to_mis got done %b mis %b err %b exp 1 1 0", done2, misalign2, bus_err2);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_en = 1'b1; MemRW = 1'b0; DataRSel = 3'b000; addr = 32'h6004;
        bus.bus_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bus_req !== 1'b1) begin
            errors++; $display("FAIL rm_req got %b exp 1", bus.bus_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rm_req_drop got req %b stall %b exp 0 0", bus.bus_req, stall);
        end
        mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_en = 1'b1; addr = 32'h6008;
        @(negedge clk);
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({stall, done, misalign, bus_err, rdata, bus.bus_req, bus.bus_we} !== 38'h0 ||
            {bus.bus_addr, bus.bus_be, bus.bus_wdata} !== 68'h0) begin
            errors++;
            $display("FAIL rm_resp got st %b dn %b rq %b a %h be %b exp all 0",
                     stall, done, bus.bus_req, bus.bus_addr, bus.bus_be);
        end
        mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.bus_rvalid = 1'b1;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || stall !== 1'b0 || bus.bus_req !== 1'b0) begin
            errors++; $display("FAIL rm_ignore got done %b stall %b req %b exp 0 0 0", done, stall, bus.bus_req);
        end
        do_access(1'b0, 2'b00, 3'b000, 32'h6000, 32'h0, 32'h0BAD_F00D, 0);
        checks++;
        if (r_lat !== 3 || r_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL rm_clean got lat %0d rd %h exp 3 0BADF00D", r_lat, r_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 2'b00, 3'b000, 32'h7000, 32'hCAFE_F00D, 32'h0, 0);
        checks++;
        if (r_be !== 4'b1111 || r_wd !== 32'hCAFE_F00D || r_we !== 1'b1) begin
            errors++; $display("FAIL b2b_sw got be %b wd %h we %b exp 1111 CAFEF00D 1", r_be, r_wd, r_we);
        end
        do_access(1'b0, 2'b00, 3'b001, 32'h7001, 32'h0, 32'h0000_7F00, 0);
        checks++;
        if (r_rdata !== 32'h0000_007F || r_be !== 4'b0010 || r_lat !== 3) begin
            errors++; $display("FAIL b2b_lb got %h be %b lat %0d exp 0000007F 0010 3", r_rdata, r_be, r_lat);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_byte();
        test_load_half_wait();
        test_load_word();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

endmodule
